// File: rtl/ocspm_cdma.sv
`default_nettype none
// ocspm_cdma -- byte-wide DMA between an external Wishbone space and the scratchpad cDMA port.
// Revision 1.0
module ocspm_cdma #(
  parameter int SPM_AWID = 10,
  parameter int EXT_AWID = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          CFG_ADRi,
  input  logic [7:0]          CFG_DATi,
  output logic [7:0]          CFG_DATo,
  input  logic                CFG_WEi,
  input  logic                CFG_CYCi,
  input  logic                CFG_STBi,
  output logic                CFG_ACKo,
  output logic [EXT_AWID-1:0] M_ADRo,
  output logic [7:0]          M_DATo,
  input  logic [7:0]          M_DATi,
  output logic                M_WEo,
  output logic                M_CYCo,
  output logic                M_STBo,
  input  logic                M_ACKi,
  output logic [7:0]          spm_dat_o,
  input  logic [7:0]          spm_dat_i,
  output logic                dma_req,
  output logic [SPM_AWID-1:0] dmaaddr,
  output logic                spm_we,
  output logic                irq
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXT_RD  = 3'd1,
    S_SPM_WR  = 3'd2,
    S_SPM_RD  = 3'd3,
    S_SPM_CAP = 3'd4,
    S_EXT_WR  = 3'd5,
    S_NEXT    = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [EXT_AWID-1:0] ext_q, ext_d;
  logic [SPM_AWID-1:0] spm_q, spm_d;
  logic [15:0]         len_q, len_d;
  logic                dir_q, dir_d;
  logic                ie_q, ie_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;
  logic                abort_pend_q, abort_pend_d;
  logic [7:0]          buf_q, buf_d;
  logic                ack_q;
  logic                m_cyc_q, m_we_q, dma_req_q, spm_we_q, irq_q;

  logic                w_idle;
  logic                w_wr;
  logic [15:0]         w_ext_rd;
  logic [15:0]         w_spm_rd;

  assign w_idle   = (state_q == S_IDLE);
  assign w_wr     = ack_q & CFG_CYCi & CFG_STBi & CFG_WEi;
  assign w_ext_rd = 16'(ext_q);
  assign w_spm_rd = 16'(spm_q);

  assign CFG_ACKo  = ack_q;
  assign M_ADRo    = ext_q;
  assign M_DATo    = buf_q;
  assign M_WEo     = m_we_q;
  assign M_CYCo    = m_cyc_q;
  assign M_STBo    = m_cyc_q;
  assign spm_dat_o = buf_q;
  assign dma_req   = dma_req_q;
  assign dmaaddr   = spm_q;
  assign spm_we    = spm_we_q;
  assign irq       = irq_q;

  always_comb begin
    CFG_DATo = 8'h00;
    case (CFG_ADRi)
      3'd0: CFG_DATo = w_ext_rd[7:0];
      3'd1: CFG_DATo = w_ext_rd[15:8];
      3'd2: CFG_DATo = w_spm_rd[7:0];
      3'd3: CFG_DATo = w_spm_rd[15:8];
      3'd4: CFG_DATo = len_q[7:0];
      3'd5: CFG_DATo = len_q[15:8];
      3'd6: CFG_DATo = {5'b0, ie_q, dir_q, 1'b0};
      3'd7: CFG_DATo = {5'b0, aborted_q, done_q, ~w_idle};
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    ext_d        = ext_q;
    spm_d        = spm_q;
    len_d        = len_q;
    dir_d        = dir_q;
    ie_d         = ie_q;
    done_d       = done_q;
    aborted_d    = aborted_q;
    abort_pend_d = abort_pend_q;
    buf_d        = buf_q;

    // Configuration writes; address/length/mode are frozen while a transfer runs.
    if (w_wr) begin
      case (CFG_ADRi)
        3'd0: if (w_idle) ext_d = EXT_AWID'({w_ext_rd[15:8], CFG_DATi});
        3'd1: if (w_idle) ext_d = EXT_AWID'({CFG_DATi, w_ext_rd[7:0]});
        3'd2: if (w_idle) spm_d = SPM_AWID'({w_spm_rd[15:8], CFG_DATi});
        3'd3: if (w_idle) spm_d = SPM_AWID'({CFG_DATi, w_spm_rd[7:0]});
        3'd4: if (w_idle) len_d = {len_q[15:8], CFG_DATi};
        3'd5: if (w_idle) len_d = {CFG_DATi, len_q[7:0]};
        3'd6: begin
          if (w_idle) begin
            dir_d = CFG_DATi[1];
            ie_d  = CFG_DATi[2];
            if (CFG_DATi[0]) begin
              done_d       = 1'b0;
              aborted_d    = 1'b0;
              abort_pend_d = 1'b0;
              if (len_q == 16'd0) done_d = 1'b1;
              else                state_d = CFG_DATi[1] ? S_SPM_RD : S_EXT_RD;
            end
          end else if (CFG_DATi[3]) begin
            abort_pend_d = 1'b1;
          end
        end
        3'd7: begin
          if (CFG_DATi[1]) done_d    = 1'b0;
          if (CFG_DATi[2]) aborted_d = 1'b0;
        end
        default: ;
      endcase
    end

    case (state_q)
      S_EXT_RD: if (M_ACKi) begin
        buf_d   = M_DATi;
        state_d = S_SPM_WR;
      end
      S_SPM_WR:  state_d = S_NEXT;
      S_SPM_RD:  state_d = S_SPM_CAP;
      S_SPM_CAP: begin
        buf_d   = spm_dat_i;
        state_d = S_EXT_WR;
      end
      S_EXT_WR: if (M_ACKi) state_d = S_NEXT;
      // Byte boundary: the only point where completion or abort can end the run.
      S_NEXT: begin
        ext_d = ext_q + EXT_AWID'(1);
        spm_d = spm_q + SPM_AWID'(1);
        len_d = len_q - 16'd1;
        if (len_q == 16'd1) begin
          done_d       = 1'b1;
          abort_pend_d = 1'b0;
          state_d      = S_IDLE;
        end else if (abort_pend_q) begin
          aborted_d    = 1'b1;
          abort_pend_d = 1'b0;
          state_d      = S_IDLE;
        end else begin
          state_d = dir_q ? S_SPM_RD : S_EXT_RD;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      ext_q        <= '0;
      spm_q        <= '0;
      len_q        <= '0;
      dir_q        <= 1'b0;
      ie_q         <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      buf_q        <= '0;
      ack_q        <= 1'b0;
      m_cyc_q      <= 1'b0;
      m_we_q       <= 1'b0;
      dma_req_q    <= 1'b0;
      spm_we_q     <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ext_q        <= ext_d;
      spm_q        <= spm_d;
      len_q        <= len_d;
      dir_q        <= dir_d;
      ie_q         <= ie_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      abort_pend_q <= abort_pend_d;
      buf_q        <= buf_d;
      ack_q        <= CFG_CYCi & CFG_STBi & ~ack_q;
      // Bus controls are decoded from the next state so they line up with it.
      m_cyc_q      <= (state_d == S_EXT_RD) || (state_d == S_EXT_WR);
      m_we_q       <= (state_d == S_EXT_WR);
      dma_req_q    <= (state_d == S_SPM_WR) || (state_d == S_SPM_RD) || (state_d == S_SPM_CAP);
      spm_we_q     <= (state_d == S_SPM_WR);
      irq_q        <= ie_d & (done_d | aborted_d);
    end
  end

endmodule
`default_nettype wire

// File: doc/ocspm_cdma.md
Name: ocspm_cdma

Overview:
- Byte-wide DMA engine that drives the scratchpad memory's cDMA port.
- Copies blocks between an external Wishbone space and the scratchpad, in either direction.
- Configured by the CPU through a small 8-bit Wishbone slave register file.
- While it owns the scratchpad, it holds dma_req high. The scratchpad masks its own CPU acknowledge during that time, so CPU scratchpad accesses stall.

Parameters:
- SPM_AWID, 10, scratchpad address width. Scratchpad addresses wrap modulo 2^SPM_AWID.
- EXT_AWID, 16, external master address width. External addresses wrap modulo 2^EXT_AWID.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- CFG_ADRi  in  3  register select
- CFG_DATi  in  8  register write data
- CFG_DATo  out  8  register read data
- CFG_WEi, CFG_CYCi, CFG_STBi  in  1 each  Wishbone slave controls
- CFG_ACKo  out  1  slave acknowledge
- M_ADRo  out  EXT_AWID  master address
- M_DATo  out  8  master write data
- M_DATi  in  8  master read data
- M_WEo, M_CYCo, M_STBo  out  1 each  master controls
- M_ACKi  in  1  master acknowledge
- spm_dat_o  out  8  data to scratchpad (its dat_i)
- spm_dat_i  in  8  data from scratchpad (its dat_o)
- dma_req  out  1  scratchpad ownership request
- dmaaddr  out  SPM_AWID  scratchpad address
- spm_we  out  1  scratchpad write enable
- irq  out  1  completion interrupt

Behaviour:
- Reset (rst=0, asynchronous): all registers, outputs and FSM state are 0; FSM goes to IDLE; M_CYCo, M_STBo, dma_req and irq drop immediately.
- Register map:
  - 0 EXT_L, 1 EXT_H: external address.
  - 2 SPM_L, 3 SPM_H: scratchpad address; bits above SPM_AWID are read 0.
  - 4 LEN_L, 5 LEN_H: 16-bit byte count.
  - 6 CTRL: bit0 START (write-1 pulse, reads 0); bit1 DIR (0 = ext->spm, 1 = spm->ext); bit2 IE; bit3 ABORT (write-1 pulse).
  - 7 STATUS: bit0 BUSY (RO); bit1 DONE (write-1-to-clear); bit2 ABORTED (write-1-to-clear).
- Reads of address and length registers return their live, incrementing and decrementing values.
- CFG_ACKo is registered: set the cycle after CYC&STB, high for exactly one cycle per access (ack <= CYC & STB & ~ack). Write side effects take place on the acked cycle.
- While BUSY, writes to registers 0–5 and to DIR/IE are ignored; only ABORT and the STATUS clears take effect.
- START with LEN=0 sets DONE the next cycle with no bus activity.
- START while BUSY is ignored.
- START clears DONE and ABORTED.
- FSM states: IDLE, EXT_RD, SPM_WR, SPM_RD, SPM_CAP, EXT_WR, NEXT.
  - IDLE: on START with LEN≠0, go to EXT_RD if DIR=0, else SPM_RD.
  - EXT_RD: CYC=STB=1, WE=0, M_ADRo=EXT. On M_ACKi, latch M_DATi into the buffer and go to SPM_WR.
  - SPM_WR: dma_req=1, spm_we=1, dmaaddr=SPM, spm_dat_o=buffer, for one cycle; then NEXT.
  - SPM_RD: dma_req=1, spm_we=0, dmaaddr=SPM; then SPM_CAP.
  - SPM_CAP: dma_req and dmaaddr held; latch spm_dat_i into the buffer at the end of the cycle; then EXT_WR.
  - EXT_WR: CYC=STB=WE=1, M_DATo=buffer. On M_ACKi, go to NEXT.
  - NEXT: EXT+1 and SPM+1, each wrapping; LEN-1.
    - If LEN becomes 0: set DONE, go to IDLE.
    - Else if an abort is pending: set ABORTED, go to IDLE.
    - Else start the next byte.
- Abort takes effect only at a byte boundary (NEXT); an in-flight master handshake always completes.
- dma_req is 0 in IDLE, EXT_RD, EXT_WR and NEXT, so the CPU can reach the scratchpad between bytes.
- Master strobes are never issued outside EXT_RD and EXT_WR.
- BUSY=1 whenever the FSM is not in IDLE.
- irq = IE & (DONE | ABORTED), level output.
- Throughput with a zero-wait external slave (ACK the cycle after STB):
  - ext->spm: 4 cycles/byte.
  - spm->ext: 5 cycles/byte.
- A slave that never acks stalls the engine indefinitely; only rst recovers it.

Test Plan:
- Register access: write EXT=0x1234, SPM=0x3F0, LEN=3 and read them back. Each access gets exactly one CFG_ACKo pulse, one cycle after STB.
- ext->spm: external memory at 0x1234..0x1236 holds AA,BB,CC; SPM=0x3FE, LEN=3, START with IE=1.
  - Scratchpad gets 0x3FE=AA, 0x3FF=BB, 0x000=CC (wrap).
  - Afterwards EXT=0x1237, LEN=0, DONE=1, irq=1, BUSY=0.
- spm->ext: scratchpad 0x010..0x011 = 5A,A5; EXT=0xFFFF, LEN=2, DIR=1.
  - External writes: 0xFFFF=5A, 0x0000=A5.
  - spm_dat_i is sampled in SPM_CAP, one cycle after SPM_RD.
- Abort: LEN=100; write ABORT during the 3rd byte's EXT_RD held off by a slow ack.
  - Exactly 3 bytes are transferred, ABORTED=1, DONE=0, LEN=97.
- Edge cases:
  - LEN=0 START gives DONE with M_CYCo never asserted.
  - A write to EXT_L while BUSY is ignored.
  - Writing 0x02 to STATUS clears DONE and drops irq.
- Asynchronous reset mid-EXT_WR: M_CYCo, dma_req and irq go to 0 without a clock edge, and all registers read 0 after reset is released.
